// File: rtl/fim_rdack_mux_pkg.sv
// Shared types and helpers for the rdack round-robin mux.
// Optional macro FIM_RDACK_RR_MUX_STATS_EN enables per-source packet counters.
package fim_rdack_mux_pkg;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } mux_state_e;

  localparam int STAT_W = 32;

  function automatic int src_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fim_rr_arb.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
// The pointer register lives in the caller.
module fim_rr_arb
  import fim_rdack_mux_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt_onehot,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  int idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!gnt_any && req[idx]) begin
        gnt_any         = 1'b1;
        gnt_idx         = SRC_W'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fim_rdack_rr_mux.sv
// Round-robin scheduler sharing one output register between NUM_SRC rdack FIFO read ports.
// Optional macro FIM_RDACK_RR_MUX_STATS_EN adds stat_sel/stat_pkts packet counters.
//
//   state    | meaning
//   UNLOCKED | free arbitration among valid sources from rr_ptr
//   LOCKED   | grant held on lock_src until a beat with last=1 is consumed
module fim_rdack_rr_mux
  import fim_rdack_mux_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PKT_MODE   = 1,
  parameter int SRC_W      = src_w(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_rvalid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_rdata,
  input  logic [NUM_SRC-1:0]            src_last,
  output logic [NUM_SRC-1:0]            src_rdack,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [SRC_W-1:0]              out_src,
  input  logic                          out_ready,
  output logic                          locked
`ifdef FIM_RDACK_RR_MUX_STATS_EN
  ,
  input  logic [SRC_W-1:0]              stat_sel,
  output logic [STAT_W-1:0]             stat_pkts
`endif
);

  localparam logic [0:0] ST_UNLOCKED = 1'(UNLOCKED);
  localparam logic [0:0] ST_LOCKED   = 1'(LOCKED);

  logic [0:0]            state;
  logic [SRC_W-1:0]      rr_ptr;
  logic [SRC_W-1:0]      lock_src;

  logic                  load;
  logic                  fire;
  logic                  cand_valid;
  logic [SRC_W-1:0]      cand;
  logic [SRC_W-1:0]      nxt_ptr;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  beat_last;

  logic [NUM_SRC-1:0]    arb_onehot;
  logic [SRC_W-1:0]      arb_idx;
  logic                  arb_any;

  logic [DATA_WIDTH-1:0] src_data_a [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_data_a[g] = src_rdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  fim_rr_arb #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_arb (
    .req        (src_rvalid),
    .ptr        (rr_ptr),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  // rst_n gates the strobe so no beat is popped from the FIFOs while held in reset
  always_comb begin
    load = ~out_valid | out_ready;
    if (state == ST_LOCKED) begin
      cand       = lock_src;
      cand_valid = src_rvalid[lock_src];
    end else begin
      cand       = arb_idx;
      cand_valid = arb_any;
    end
    fire      = rst_n & load & cand_valid;
    beat_data = src_data_a[cand];
    beat_last = src_last[cand];
    nxt_ptr   = (int'(cand) == NUM_SRC - 1) ? '0 : cand + SRC_W'(1);
    src_rdack = '0;
    if (fire) src_rdack[cand] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
      state     <= ST_UNLOCKED;
      rr_ptr    <= '0;
      lock_src  <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= beat_data;
      out_last  <= beat_last;
      out_src   <= cand;
      if (PKT_MODE != 0) begin
        if (beat_last) begin
          state  <= ST_UNLOCKED;
          rr_ptr <= nxt_ptr;
        end else begin
          state    <= ST_LOCKED;
          lock_src <= cand;
        end
      end else begin
        rr_ptr <= nxt_ptr;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign locked = (state == ST_LOCKED);

`ifdef FIM_RDACK_RR_MUX_STATS_EN
  logic [STAT_W-1:0] pkt_cnt [NUM_SRC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) pkt_cnt[i] <= '0;
      stat_pkts <= '0;
    end else begin
      if (fire && beat_last) pkt_cnt[cand] <= pkt_cnt[cand] + STAT_W'(1);
      stat_pkts <= (int'(stat_sel) < NUM_SRC) ? pkt_cnt[stat_sel] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_fim_rdack_rr_mux.sv
// Scoreboard bench for fim_rdack_rr_mux: behavioural source FIFOs and arbiter model.
// Stats checks are compiled in when FIM_RDACK_RR_MUX_STATS_EN is defined.
module tb_fim_rdack_rr_mux;
  import fim_rdack_mux_pkg::*;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int PM = 1;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NS-1:0]    src_rvalid;
  logic [NS*DW-1:0] src_rdata;
  logic [NS-1:0]    src_last;
  logic [NS-1:0]    src_rdack;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic [SW-1:0]    out_src;
  logic             out_ready;
  logic             locked;
`ifdef FIM_RDACK_RR_MUX_STATS_EN
  logic [SW-1:0]    stat_sel;
  logic [31:0]      stat_pkts;
`endif

  always #5 clk = ~clk;

  fim_rdack_rr_mux #(
    .NUM_SRC    (NS),
    .DATA_WIDTH (DW),
    .PKT_MODE   (PM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_rvalid (src_rvalid),
    .src_rdata  (src_rdata),
    .src_last   (src_last),
    .src_rdack  (src_rdack),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .locked     (locked)
`ifdef FIM_RDACK_RR_MUX_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_pkts  (stat_pkts)
`endif
  );

  typedef struct packed {
    logic [SW-1:0] src;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic [DW:0]   srcq [NS][$];
  beat_t         sb [$];
  int            src_log [$];
  logic [NS-1:0] en;
  logic          rdy;
  logic          m_ov;
  logic          m_locked;
  int            m_ptr;
  int            m_lock;
  int            seq;
  int            n_tests;
  int            n_fail;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_pkt(input int s, input int n);
    for (int b = 0; b < n; b++) begin
      logic [DW-1:0] d;
      d = DW'((s << 24) | ((seq & 'hffff) << 8) | b);
      seq++;
      srcq[s].push_back({(b == n - 1), d});
    end
  endtask

  task automatic model_reset();
    m_ov = 1'b0;
    m_locked = 1'b0;
    m_ptr = 0;
    m_lock = 0;
    sb.delete();
    for (int i = 0; i < NS; i++) srcq[i].delete();
  endtask

  // One cycle: drive at negedge, check just after, advance model for the coming posedge
  task automatic step();
    logic [NS-1:0] rv;
    logic [NS-1:0] exp_ack;
    logic [DW:0]   hd;
    logic          cv;
    logic          fire;
    int            c;
    beat_t         bt;
    @(negedge clk);
    rv = '0;
    for (int i = 0; i < NS; i++) begin
      if (en[i] && srcq[i].size() > 0) begin
        hd = srcq[i][0];
        rv[i] = 1'b1;
        src_rdata[i*DW +: DW] = hd[DW-1:0];
        src_last[i] = hd[DW];
      end
    end
    src_rvalid = rv;
    out_ready = rdy;
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("locked", locked, m_locked);
    if (m_ov) begin
      chk("sb_nonempty", sb.size(), 1);
      if (sb.size() > 0) begin
        chk("out_data", out_data, sb[0].data);
        chk("out_last", out_last, sb[0].last);
        chk("out_src", out_src, sb[0].src);
      end
    end
    cv = 1'b0;
    c = 0;
    if (m_locked) begin
      c = m_lock;
      cv = rv[c];
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (!cv && rv[(m_ptr + k) % NS]) begin
          cv = 1'b1;
          c = (m_ptr + k) % NS;
        end
      end
    end
    fire = (!m_ov || rdy) && cv;
    exp_ack = '0;
    if (fire) exp_ack[c] = 1'b1;
    chk("src_rdack", src_rdack, exp_ack);
    if (m_ov && rdy && sb.size() > 0) begin
      bt = sb.pop_front();
      src_log.push_back(int'(bt.src));
    end
    if (fire) begin
      hd = srcq[c].pop_front();
      bt.src = SW'(c);
      bt.last = hd[DW];
      bt.data = hd[DW-1:0];
      sb.push_back(bt);
      m_ov = 1'b1;
      if (PM != 0) begin
        if (bt.last) begin
          m_locked = 1'b0;
          m_ptr = (c + 1) % NS;
        end else begin
          m_locked = 1'b1;
          m_lock = c;
        end
      end else begin
        m_ptr = (c + 1) % NS;
      end
    end else if (rdy) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    rdy = 1'b1;
    en = '1;
    for (int n = 0; n < 300 && !done; n++) begin
      done = !m_ov && sb.size() == 0;
      for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) done = 1'b0;
      if (!done) step();
    end
    chk("drain_done", done, 1);
  endtask

  task automatic chk_log(input string tag, input int exp_q[$]);
    chk({tag, "_len"}, src_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < src_log.size(); k++)
      chk(tag, src_log[k], exp_q[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            ack2;
    logic [DW-1:0] hold_d;
    logic [SW-1:0] hold_s;
    int            exp_q [$];
    n_tests = 0;
    n_fail = 0;
    seq = 0;
    src_rvalid = '0;
    src_rdata = '0;
    src_last = '0;
    out_ready = 1'b0;
    en = '0;
    rdy = 1'b0;
`ifdef FIM_RDACK_RR_MUX_STATS_EN
    stat_sel = '0;
`endif
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_locked", locked, 0);
    chk("rst_rdack", src_rdack, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // fairness with single-beat packets
    src_log.delete();
    for (int r = 0; r < 3; r++) for (int s = 0; s < NS; s++) push_pkt(s, 1);
    drain();
    exp_q = {0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    chk_log("fair_seq", exp_q);

    // packet hold
    src_log.delete();
    push_pkt(0, 3);
    for (int r = 0; r < 3; r++) push_pkt(1, 1);
    drain();
    exp_q = {0, 0, 0, 1, 1, 1};
    chk_log("hold_seq", exp_q);

    // stall while locked on src0
    src_log.delete();
    push_pkt(0, 3);
    en = '1;
    rdy = 1'b1;
    step();
    push_pkt(2, 1);
    push_pkt(2, 1);
    en[0] = 1'b0;
    ack2 = 0;
    repeat (5) begin
      step();
      if (src_rdack[2]) ack2++;
    end
    chk("stall_no_rdack2", ack2, 0);
    chk("stall_drained", out_valid, 0);
    chk("stall_locked", locked, 1);
    drain();
    exp_q = {0, 0, 0, 2, 2};
    chk_log("stall_seq", exp_q);

    // backpressure
    src_log.delete();
    for (int r = 0; r < 3; r++) begin
      push_pkt(1, 1);
      push_pkt(3, 1);
    end
    en = '1;
    rdy = 1'b1;
    step();
    step();
    rdy = 1'b0;
    step();
    hold_d = out_data;
    hold_s = out_src;
    repeat (3) begin
      step();
      chk("bp_rdack", src_rdack, 0);
      chk("bp_data", out_data, hold_d);
      chk("bp_src", out_src, hold_s);
    end
    rdy = 1'b1;
    step();
    step();
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_new", out_data != hold_d, 1);
    drain();

    // reset while locked on src3
    push_pkt(3, 3);
    en = '1;
    rdy = 1'b1;
    step();
    step();
    chk("pre_rst_locked", locked, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_rdack", src_rdack, 0);
    model_reset();
    src_rvalid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    push_pkt(3, 1);
    push_pkt(1, 1);
    step();
    chk("rst_first_gnt", src_rdack, 4'b0010);
    drain();

`ifdef FIM_RDACK_RR_MUX_STATS_EN
    for (int p = 0; p < 7; p++) push_pkt(2, 2);
    drain();
    stat_sel = 2'd2;
    step();
    step();
    chk("stat_src2", stat_pkts, 7);
    stat_sel = 2'd0;
    step();
    step();
    chk("stat_src0", stat_pkts, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
